pll_reset_sequencer: RTL and testbench

- Sits directly downstream of the system PLL wrapper and runs on its primary output clock (57.175925 MHz).
- Synchronises the PLL `locked` flag and filters it for stability.
- Sequences the core reset release and generates the core's clock-enable pulses (`ce`, `ce_n`).
- Every downstream block takes its reset and clock enables from this block, never from `locked` directly.

---
 rtl/pll_reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL lock synchroniser, stability filter, core reset sequencer and clock-enable generator.
// Optional lock-loss counter enabled by defining LOCK_LOSS_CNT_EN.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CE_DIV        = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       locked,
  output logic       rst_out,
  output logic       ready,
  output logic       ce,
  output logic       ce_n,
  output logic [1:0] state
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int unsigned MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned DIV_W      = $clog2(CE_DIV);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   div_active;
  logic                   rst_out_d, ready_d, ce_d, ce_n_d;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0]             llc_q, llc_d;
`endif

  // Only the synchroniser sees the asynchronous locked flag
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      div_q   <= '0;
      rst_out <= 1'b1;
      ready   <= 1'b0;
      ce      <= 1'b0;
      ce_n    <= 1'b0;
`ifdef LOCK_LOSS_CNT_EN
      llc_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rst_out <= rst_out_d;
      ready   <= ready_d;
      ce      <= ce_d;
      ce_n    <= ce_n_d;
`ifdef LOCK_LOSS_CNT_EN
      llc_q   <= llc_d;
`endif
    end
  end

  // Loss of locked_s wins over every count-driven transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Divider only runs while both current and next state keep enables alive
    div_active = ((state_q == HOLD) || (state_q == RUN)) &&
                 ((state_d == HOLD) || (state_d == RUN));
    if (!div_active)                         div_d = '0;
    else if (div_q == DIV_W'(CE_DIV - 1))    div_d = '0;
    else                                     div_d = div_q + DIV_W'(1);
    ce_d      = div_active && (div_q == DIV_W'(CE_DIV - 1));
    ce_n_d    = div_active && (div_q == DIV_W'(CE_DIV / 2 - 1));
    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);

`ifdef LOCK_LOSS_CNT_EN
    llc_d = llc_q;
    if ((state_q == RUN) && (state_d == WAIT_LOCK) && (llc_q != 8'hFF))
      llc_d = llc_q + 8'd1;
`endif
  end

  assign state = state_q;
`ifdef LOCK_LOSS_CNT_EN
  assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised self-checking bench for pll_reset_sequencer; model tracks run length of high lock samples.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int ST   = 8;
  localparam int HD   = 4;
  localparam int DIV  = 4;
  localparam int REL  = SYNC + ST + HD + 1;

  logic       clk_sys = 1'b0;
  logic       rst     = 1'b1;
  logic       locked  = 1'b0;
  logic       rst_out, ready, ce, ce_n;
  logic [1:0] state;
  logic [5:0] dut_vec;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .CE_DIV(DIV)
  ) dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .locked(locked),
    .rst_out(rst_out),
    .ready(ready),
    .ce(ce),
    .ce_n(ce_n),
    .state(state)
`ifdef LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  assign dut_vec = {state, rst_out, ready, ce, ce_n};

  // Reference model: m_run = consecutive high lock samples the sequencer has seen so far
  bit q[$];
  int m_run = 0;
  int m_llc = 0;

  function automatic int exp_state(int r);
    if (r == 0)            return 0;
    else if (r <= ST)      return 1;
    else if (r <= ST + HD) return 2;
    else                   return 3;
  endfunction

  function automatic logic [5:0] exp_vec(int r);
    int s;
    int k;
    logic c, cn;
    s  = exp_state(r);
    c  = 1'b0;
    cn = 1'b0;
    if (s >= 2) begin
      k  = r - ST - 1;
      c  = (k > 0) && (k % DIV == 0);
      cn = (k % DIV == DIV / 2);
    end
    return {2'(s), (s != 3), (s == 3), c, cn};
  endfunction

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      q.delete();
      m_run = 0;
      m_llc = 0;
    end else begin
      int prev;
      prev = exp_state(m_run);
      q.push_back(locked);
      if (q.size() > 8) void'(q.pop_front());
      if (q.size() > SYNC) m_run = q[q.size() - 1 - SYNC] ? m_run + 1 : 0;
      if (prev == 3 && exp_state(m_run) == 0 && m_llc < 255) m_llc++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    checks++;
    if (dut_vec !== 6'b001000) begin
      failures++;
      $display("FAIL reset_values: got %b expected %b", dut_vec, 6'b001000);
    end
`ifdef LOCK_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_llc: got %0d expected 0", lock_loss_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_clean_release();
    int n = -1, code = 0, hold_entry = -1, first_ce = -1, first_cen = -1, early_ce = 0;
    logic [1:0] last = 2'd0;
    apply_reset();
    tick();
    locked = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec(m_run)) begin
        failures++;
        $display("FAIL clean_model edge %0d: got %b expected %b", i, dut_vec, exp_vec(m_run));
      end
      if (state != last) begin
        code = code * 4 + int'(state);
        last = state;
      end
      if (hold_entry < 0 && state == 2'd2) hold_entry = i;
      if (hold_entry < 0 && (ce || ce_n)) early_ce++;
      if (first_ce < 0 && ce) first_ce = i;
      if (first_cen < 0 && ce_n) first_cen = i;
      if (n < 0 && rst_out == 1'b0 && ready == 1'b1) n = i;
    end
    checks++;
    if (n != REL) begin
      failures++;
      $display("FAIL release_latency: got %0d expected %0d", n, REL);
    end
    checks++;
    if (code != 27) begin
      failures++;
      $display("FAIL state_sequence: got code %0d expected 27 (1,2,3)", code);
    end
    checks++;
    if (hold_entry != SYNC + ST + 1) begin
      failures++;
      $display("FAIL hold_entry: got %0d expected %0d", hold_entry, SYNC + ST + 1);
    end
    checks++;
    if (early_ce != 0) begin
      failures++;
      $display("FAIL ce_before_hold: got %0d pulses expected 0", early_ce);
    end
    checks++;
    if (first_cen != hold_entry + DIV / 2) begin
      failures++;
      $display("FAIL first_ce_n: got %0d expected %0d", first_cen, hold_entry + DIV / 2);
    end
    checks++;
    if (first_ce != hold_entry + DIV) begin
      failures++;
      $display("FAIL first_ce: got %0d expected %0d", first_ce, hold_entry + DIV);
    end
  endtask

  task automatic test_glitch_stable();
    int seen = 0, n = -1, saw_wait = 0, early_rel = 0;
    apply_reset();
    locked = 1'b1;
    for (int i = 0; i < 30 && seen < 5; i++) begin
      tick();
      if (state == 2'd1) seen++;
    end
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec(m_run)) begin
        failures++;
        $display("FAIL glitch_model edge %0d: got %b expected %b", i, dut_vec, exp_vec(m_run));
      end
      if (state == 2'd0) saw_wait++;
      if (n < 0 && rst_out == 1'b0) n = i;
      if (i < REL && rst_out == 1'b0) early_rel++;
    end
    checks++;
    if (saw_wait == 0 || early_rel != 0) begin
      failures++;
      $display("FAIL glitch_return: wait_cycles %0d early_release %0d expected >0 and 0", saw_wait, early_rel);
    end
    checks++;
    if (n != REL) begin
      failures++;
      $display("FAIL glitch_release_latency: got %0d expected %0d", n, REL);
    end
  endtask

  task automatic test_run_loss();
    apply_reset();
    locked = 1'b1;
    repeat (REL + 2) tick();
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL run_reached: ready %b expected 1", ready);
    end
`ifdef LOCK_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL llc_before_loss: got %0d expected 0", lock_loss_cnt);
    end
`endif
    locked = 1'b0;
    for (int i = 1; i <= SYNC; i++) begin
      tick();
      checks++;
      if ({state, rst_out, ready} !== 4'b1101) begin
        failures++;
        $display("FAIL loss_early edge %0d: got %b expected 1101", i, {state, rst_out, ready});
      end
    end
    tick();
    checks++;
    if (dut_vec !== 6'b001000) begin
      failures++;
      $display("FAIL loss_edge3: got %b expected 001000", dut_vec);
    end
`ifdef LOCK_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL llc_after_loss: got %0d expected 1", lock_loss_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    locked = 1'b1;
    repeat (REL + 3) tick();
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_run: ready %b expected 1", ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 6'b001000) begin
      failures++;
      $display("FAIL async_reset_values: got %b expected 001000", dut_vec);
    end
`ifdef LOCK_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_llc: got %0d expected 0", lock_loss_cnt);
    end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int seg = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        locked = ~locked;
        seg    = locked ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 4));
      end
      seg--;
      tick();
      checks++;
      if (dut_vec !== exp_vec(m_run)) begin
        failures++;
        $display("FAIL random_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec(m_run));
      end
`ifdef LOCK_LOSS_CNT_EN
      checks++;
      if (int'(lock_loss_cnt) != m_llc) begin
        failures++;
        $display("FAIL random_llc cycle %0d: got %0d expected %0d", i, lock_loss_cnt, m_llc);
      end
`endif
    end
  endtask

`ifdef LOCK_LOSS_CNT_EN
  task automatic test_saturation();
    apply_reset();
    for (int l = 0; l < 260; l++) begin
      locked = 1'b1;
      repeat (REL + 1) tick();
      locked = 1'b0;
      repeat (SYNC + 2) tick();
      checks++;
      if (int'(lock_loss_cnt) != m_llc) begin
        failures++;
        $display("FAIL sat_model loop %0d: got %0d expected %0d", l, lock_loss_cnt, m_llc);
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      failures++;
      $display("FAIL llc_saturated: got %0d expected 255", lock_loss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_release();
    test_glitch_stable();
    test_run_loss();
    test_async_reset();
    test_random();
`ifdef LOCK_LOSS_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
